// File: rtl/keccak_pad_absorber_if.sv
// Byte-stream input and Keccak lane output handshakes of the pad/absorb block.
// slave is the absorber's view; master is the FIFO / permutation-core side.
interface keccak_pad_absorber_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        lane_valid;
    logic        lane_ready;
    logic [63:0] lane_data;
    logic [4:0]  lane_idx;
    logic        blk_last;
    logic        msg_final;

    modport slave (
        input  in_valid, in_data, in_last, lane_ready,
        output in_ready, lane_valid, lane_data, lane_idx, blk_last, msg_final
    );

    modport master (
        output in_valid, in_data, in_last, lane_ready,
        input  in_ready, lane_valid, lane_data, lane_idx, blk_last, msg_final
    );
endinterface

// File: rtl/keccak_pad_absorber.sv
// Packs a byte stream into 64-bit Keccak lanes and applies SHA3 multi-rate padding.
// Optional KECCAK_XOF_EN adds an xof input selecting the SHAKE domain byte.
module keccak_pad_absorber #(
    parameter logic [7:0] DOMAIN_SHA3 = 8'h06,
    parameter logic [7:0] DOMAIN_XOF  = 8'h1F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       msg_empty,
    input  logic       perm_done,
`ifdef KECCAK_XOF_EN
    input  logic       xof,
`endif
    output logic       busy,
    keccak_pad_absorber_if.slave bus
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ABSORB    = 2'd1;
    localparam logic [1:0] PAD       = 2'd2;
    localparam logic [1:0] WAIT_PERM = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  rate_lanes_q, rate_lanes_d;
    logic [63:0] lane_q, lane_d;
    logic [4:0]  lane_idx_q, lane_idx_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic        lane_valid_q, lane_valid_d;
    logic        final_q, final_d;
    logic        pend_q, pend_d;
    logic        dom_done_q, dom_done_d;
    logic [7:0]  domain;

`ifdef KECCAK_XOF_EN
    logic xof_q, xof_d;
    assign domain = xof_q ? DOMAIN_XOF : DOMAIN_SHA3;
`else
    assign domain = DOMAIN_SHA3;
`endif

    logic accept, xfer, last_lane, next_last;

    assign bus.in_ready   = (state_q == ABSORB) && !lane_valid_q;
    assign bus.lane_valid = lane_valid_q;
    assign bus.lane_data  = lane_q;
    assign bus.lane_idx   = lane_idx_q;
    assign bus.blk_last   = lane_valid_q && last_lane;
    assign bus.msg_final  = final_q;
    assign busy           = (state_q != IDLE);

    assign accept    = bus.in_ready && bus.in_valid;
    assign xfer      = lane_valid_q && bus.lane_ready;
    assign last_lane = (lane_idx_q == rate_lanes_q - 5'd1);
    assign next_last = (lane_idx_q + 5'd2 == rate_lanes_q);

    function automatic logic [4:0] rate_of(input logic [1:0] s);
        logic [4:0] r;
        unique case (s)
            2'd0:    r = 5'd18;
            2'd1:    r = 5'd17;
            2'd2:    r = 5'd13;
            default: r = 5'd9;
        endcase
        return r;
    endfunction

    // Bytes below cnt are message; the domain byte lands at cnt once per message.
    function automatic logic [63:0] pad_lane(
        input logic [63:0] base,
        input logic [2:0]  cnt,
        input logic        put_dom,
        input logic        is_last,
        input logic [7:0]  dom
    );
        logic [63:0] r;
        r = base;
        for (int k = 0; k < 8; k++) begin
            if (k >= int'(cnt))
                r[8*k +: 8] = (put_dom && k == int'(cnt)) ? dom : 8'h00;
        end
        if (is_last)
            r[63:56] = r[63:56] | 8'h80;
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        rate_lanes_d = rate_lanes_q;
        lane_d       = lane_q;
        lane_idx_d   = lane_idx_q;
        byte_cnt_d   = byte_cnt_q;
        lane_valid_d = lane_valid_q;
        final_d      = final_q;
        pend_d       = pend_q;
        dom_done_d   = dom_done_q;
`ifdef KECCAK_XOF_EN
        xof_d        = xof_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid || msg_empty) begin
                    state_d      = bus.in_valid ? ABSORB : PAD;
                    final_d      = !bus.in_valid;
                    rate_lanes_d = rate_of(sel);
                    lane_d       = 64'h0;
                    lane_idx_d   = 5'd0;
                    byte_cnt_d   = 3'd0;
                    pend_d       = 1'b0;
                    dom_done_d   = 1'b0;
`ifdef KECCAK_XOF_EN
                    xof_d        = xof;
`endif
                end
            end
            ABSORB: begin
                if (accept) begin
                    lane_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7)
                        lane_valid_d = 1'b1;
                    // A message ending on a block boundary needs a whole padding block.
                    if (bus.in_last) begin
                        if (byte_cnt_q == 3'd7 && last_lane) begin
                            pend_d = 1'b1;
                        end else begin
                            state_d = PAD;
                            final_d = 1'b1;
                        end
                    end
                end else begin
                    if (xfer) begin
                        lane_valid_d = 1'b0;
                        lane_d       = 64'h0;
                        byte_cnt_d   = 3'd0;
                        if (last_lane) begin
                            state_d    = WAIT_PERM;
                            lane_idx_d = 5'd0;
                        end else begin
                            lane_idx_d = lane_idx_q + 5'd1;
                        end
                    end
                    if (msg_empty) begin
                        if (lane_valid_q && last_lane) begin
                            pend_d = 1'b1;
                        end else begin
                            state_d = PAD;
                            final_d = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                if (!lane_valid_q) begin
                    lane_d = pad_lane(lane_q, byte_cnt_q, !dom_done_q,
                                      last_lane, domain);
                    lane_valid_d = 1'b1;
                    dom_done_d   = 1'b1;
                end else if (xfer) begin
                    byte_cnt_d = 3'd0;
                    if (last_lane) begin
                        lane_valid_d = 1'b0;
                        lane_d       = 64'h0;
                        lane_idx_d   = 5'd0;
                        state_d      = WAIT_PERM;
                    end else begin
                        lane_idx_d = lane_idx_q + 5'd1;
                        lane_d     = pad_lane(64'h0, 3'd0, !dom_done_q,
                                              next_last, domain);
                        dom_done_d = 1'b1;
                    end
                end
            end
            WAIT_PERM: begin
                if (perm_done) begin
                    if (final_q) begin
                        state_d = IDLE;
                        final_d = 1'b0;
                    end else if (pend_q) begin
                        state_d    = PAD;
                        final_d    = 1'b1;
                        pend_d     = 1'b0;
                        dom_done_d = 1'b0;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rate_lanes_q <= 5'd9;
            lane_q       <= 64'h0;
            lane_idx_q   <= 5'd0;
            byte_cnt_q   <= 3'd0;
            lane_valid_q <= 1'b0;
            final_q      <= 1'b0;
            pend_q       <= 1'b0;
            dom_done_q   <= 1'b0;
`ifdef KECCAK_XOF_EN
            xof_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rate_lanes_q <= rate_lanes_d;
            lane_q       <= lane_d;
            lane_idx_q   <= lane_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            lane_valid_q <= lane_valid_d;
            final_q      <= final_d;
            pend_q       <= pend_d;
            dom_done_q   <= dom_done_d;
`ifdef KECCAK_XOF_EN
            xof_q        <= xof_d;
`endif
        end
    end

endmodule

// File: tb/tb_keccak_pad_absorber.sv
// Directed scoreboard bench for keccak_pad_absorber (SHA3 padding reference model).
module tb_keccak_pad_absorber;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  i;
        logic        l;
        logic        f;
    } lane_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       msg_empty;
    logic       perm_done;
    logic       busy;
    logic       xof;
    logic       chk_en;
    logic [7:0] dom_b;
    logic [7:0] msg [0:255];
    lane_t      exq [$];
    lane_t      e;
    int         n_chk = 0;
    int         n_pass = 0;

    keccak_pad_absorber_if bus ();

    keccak_pad_absorber dut (
        .clk       (clk),
        .reset     (rst),
        .sel       (sel),
        .msg_empty (msg_empty),
        .perm_done (perm_done),
`ifdef KECCAK_XOF_EN
        .xof       (xof),
`endif
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int rl_of(input logic [1:0] s);
        case (s)
            2'd0:    return 18;
            2'd1:    return 17;
            2'd2:    return 13;
            default: return 9;
        endcase
    endfunction

    // Reference SHA3 pad10*1 with domain byte, split into lanes.
    task automatic push_exp(input int rl, input int len);
        logic [7:0]  pb [0:511];
        logic [63:0] d;
        int r, nblk;
        r = rl * 8;
        nblk = len / r + 1;
        for (int i = 0; i < nblk * r; i++)
            pb[i] = (i < len) ? msg[i] : 8'h00;
        pb[len] = dom_b;
        pb[nblk*r-1] = pb[nblk*r-1] | 8'h80;
        for (int b = 0; b < nblk; b++)
            for (int l = 0; l < rl; l++) begin
                for (int k = 0; k < 8; k++)
                    d[8*k +: 8] = pb[(b*rl + l)*8 + k];
                exq.push_back('{d, 5'(l), l == rl - 1, b == nblk - 1});
            end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        for (int n = 0; n < 1000 && !done; n++) begin
            if (bus.in_ready) done = 1;
            @(negedge clk);
        end
        if (!done) chk("byte_timeout", bus.in_ready, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_msg(input logic [1:0] s, input int len, input bit stall);
        int nblk;
        logic [63:0] cap_d;
        logic [4:0]  cap_i;
        nblk = len / (rl_of(s) * 8) + 1;
        push_exp(rl_of(s), len);
        sel = s;
        if (len == 0) begin
            msg_empty = 1'b1;
            @(negedge clk);
            msg_empty = 1'b0;
        end
        fork
            begin
                for (int i = 0; i < len; i++)
                    send_byte(msg[i], i == len - 1);
            end
            begin
                for (int b = 0; b < nblk; b++) begin
                    bit seen;
                    seen = 0;
                    for (int n = 0; n < 2000 && !seen; n++) begin
                        @(negedge clk);
                        if (bus.lane_valid && bus.lane_ready && bus.blk_last)
                            seen = 1;
                    end
                    if (!seen) chk("blk_timeout", 64'(b), 64'(nblk));
                    @(posedge clk);
                    repeat (3) begin
                        @(negedge clk);
                        chk("wait_no_lane", bus.lane_valid, 1'b0);
                    end
                    @(posedge clk);
                    #1 perm_done = 1'b1;
                    @(posedge clk);
                    #1 perm_done = 1'b0;
                end
            end
            begin
                if (stall) begin
                    bit hit;
                    hit = 0;
                    for (int n = 0; n < 500 && !hit; n++) begin
                        @(negedge clk);
                        hit = (bus.lane_idx == 5'd3) && !bus.lane_valid;
                    end
                    @(posedge clk);
                    #1 bus.lane_ready = 1'b0;
                    hit = 0;
                    for (int n = 0; n < 500 && !hit; n++) begin
                        @(negedge clk);
                        hit = bus.lane_valid;
                    end
                    cap_d = bus.lane_data;
                    cap_i = bus.lane_idx;
                    repeat (5) begin
                        @(negedge clk);
                        chk("stall_valid", bus.lane_valid, 1'b1);
                        chk("stall_data", bus.lane_data, cap_d);
                        chk("stall_idx", bus.lane_idx, cap_i);
                        chk("stall_ready", bus.in_ready, 1'b0);
                    end
                    @(posedge clk);
                    #1 bus.lane_ready = 1'b1;
                end
            end
        join
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        @(negedge clk);
        chk("end_idle", busy, 1'b0);
        chk("end_queue", 64'(exq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst && bus.lane_valid && bus.lane_ready) begin
            if (exq.size() == 0) begin
                chk("extra_lane", bus.lane_valid, 1'b0);
            end else begin
                e = exq.pop_front();
                chk("lane_data", bus.lane_data, e.d);
                chk("lane_idx", bus.lane_idx, e.i);
                chk("blk_last", bus.blk_last, e.l);
                if (e.l) chk("msg_final", bus.msg_final, e.f);
            end
        end
    end

    initial begin
        rst = 1'b1;
        sel = 2'd0;
        msg_empty = 1'b0;
        perm_done = 1'b0;
        xof = 1'b0;
        chk_en = 1'b1;
        dom_b = 8'h06;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_last = 1'b0;
        bus.lane_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_lane_valid", bus.lane_valid, 1'b0);
        chk("rst_blk_last", bus.blk_last, 1'b0);
        chk("rst_msg_final", bus.msg_final, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lane_data", bus.lane_data, 64'h0);
        chk("rst_lane_idx", bus.lane_idx, 5'd0);
        rst = 1'b0;
        @(negedge clk);

        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg(2'd1, 3, 0);

        run_msg(2'd3, 0, 0);

        for (int i = 0; i < 72; i++) msg[i] = 8'hAA;
        run_msg(2'd3, 71, 0);
        run_msg(2'd3, 72, 0);

        for (int i = 0; i < 40; i++) msg[i] = 8'($urandom_range(0, 255));
        run_msg(2'd0, 40, 1);

        for (int i = 0; i < 13; i++) msg[i] = 8'(i * 7 + 1);
        run_msg(2'd2, 13, 0);

        chk_en = 1'b0;
        sel = 2'd0;
        for (int i = 0; i < 20; i++) send_byte(8'(i + 8'h30), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_in_ready", bus.in_ready, 1'b0);
        chk("mid_lane_valid", bus.lane_valid, 1'b0);
        chk("mid_lane_data", bus.lane_data, 64'h0);
        chk("mid_lane_idx", bus.lane_idx, 5'd0);
        chk("mid_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exq.delete();
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 30; i++) msg[i] = 8'($urandom_range(0, 255));
        run_msg(2'd0, 30, 0);

`ifdef KECCAK_XOF_EN
        xof = 1'b1;
        dom_b = 8'h1F;
        for (int i = 0; i < 5; i++) msg[i] = 8'(i + 1);
        run_msg(2'd1, 5, 0);
        xof = 1'b0;
        dom_b = 8'h06;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
